imm_gen_stage: RTL and testbench
================================

// Module: imm_gen_stage
// PURPOSE
//  Decode-stage immediate generator with its own pipeline register. Takes a raw 32-bit RV instruction,
//  decodes the format from the opcode, builds the XLEN-wide immediate and presents it with a format code
//  and an illegal flag, one cycle later, on a valid/ready interface into EX.
//  Generalises the combinational extender: XLEN-parametrised (RV32/RV64), covers OP-IMM-32 shifts and
//  CSR zimm, supports backpressure (optional skid entry) and flush.
// PARAMETERS
//  XLEN  64  datapath width; legal values 32 or 64
//  SKID  1   0: single output register, in_ready combinational; 1: extra skid entry, in_ready registered
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  rst_n        in   1     synchronous reset, active-low
//  flush        in   1     synchronous pipeline flush (branch mispredict/trap)
//  in_valid     in   1     in_inst is valid
//  in_ready     out  1     stage can accept in_inst this cycle
//  in_inst      in   32    raw instruction
//  out_valid    out  1     out_* hold a decoded entry
//  out_ready    in   1     EX consumes the entry this cycle
//  out_imm      out  XLEN  extended immediate
//  out_fmt      out  3     0 NONE/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
//  out_illegal  out  1     opcode/shamt not legal for this XLEN
//  out_inst     out  32    instruction passed through with the entry
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_inst=0, skid empty;
//   in_ready=1 from the first cycle after reset. Reset overrides flush and any handshake.
//  Accept when in_valid&&in_ready; entry appears on out_* the next cycle (latency 1). Consume when
//   out_valid&&out_ready. out_* stay stable while out_valid&&!out_ready. Strict FIFO order; no loss/dup.
//  SKID=0: in_ready = out_ready || !out_valid.
//  SKID=1: in_ready = !skid_full (registered). Accept while out stalled -> entry goes to skid. On consume,
//   skid entry (if any) moves to out_* next cycle before any newer entry; simultaneous accept+consume
//   with skid full cannot occur (in_ready=0). Full throughput when out_ready held high.
//  flush=1: next cycle out_valid=0, skid empty, in_ready=1; an in_valid in the flush cycle is dropped.
//  Decode (opcode = inst[6:0]); sext = sign-extend to XLEN from inst[31]:
//   0010011 OP-IMM: funct3 001/101 -> SHAMT, imm = zext(inst[25:20]) (XLEN=64) or zext(inst[24:20])
//     (XLEN=32; inst[25]=1 -> illegal); other funct3 -> I, sext(inst[31:20])
//   0011011 OP-IMM-32: XLEN=64 only; shifts -> SHAMT zext(inst[24:20]); addiw -> I; XLEN=32 -> illegal
//   0000011 LOAD, 1100111 JALR -> I, sext(inst[31:20])
//   0100011 -> S, sext({inst[31:25],inst[11:7]})
//   1100011 -> B, sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})
//   0110111/0010111 -> U, sext({inst[31:12],12'b0})  (upper bits = inst[31] when XLEN=64)
//   1101111 -> J, sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})
//   1110011 SYSTEM: funct3[2]=1 -> ZIMM zext(inst[19:15]); else NONE, imm 0
//   0110011 OP, 0001111 FENCE -> NONE, imm 0; 0111011 OP-32 -> NONE (illegal if XLEN=32)
//   any other opcode -> NONE, imm 0, illegal=1
//  Illegal entries flow through the handshake like any other; the stage never blocks on them.
// TESTING
//  1 XLEN=64: addi 0xFFF00093, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFFFFFFFFFF, fmt=1
//  2 slli 0x03F09093: XLEN=64 -> imm=63, fmt=6, illegal=0; XLEN=32 -> illegal=1
//  3 XLEN=64: lui 0x800000B7 -> imm=0xFFFFFFFF80000000, fmt=4; beq 0xFE000EE3 -> imm=-4, fmt=3
//  4 SKID=1: 3 back-to-back instrs, out_ready=0 for 3 cycles -> in_ready=0 after 2nd accept; release ->
//    3 entries out in order on consecutive cycles, out_* stable during stall
//  5 SKID=1: flush with out and skid full + in_valid=1 -> next cycle out_valid=0, in_ready=1, input dropped
//  6 rst_n=0 mid-stream with out_valid=1 -> next cycle all outputs 0, in_ready=1; opcode 0x7F -> illegal=1

Source files
------------

// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
//   Decode-stage immediate generator with its own pipeline register.
//   A raw 32-bit RISC-V instruction is decoded combinationally on the input
//   side. The format code, the XLEN-wide immediate and an illegal flag are
//   registered together with the instruction. The entry appears on out_* one
//   cycle after it is accepted.
//
// Parameters
//   XLEN  datapath width, 32 or 64
//   SKID  0: single output register, in_ready is combinational
//         1: extra skid entry, in_ready is registered (!skid_full)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   flush        synchronous flush; drops out entry, skid entry and any input
//   in_valid     in_inst is valid
//   in_ready     stage can accept in_inst this cycle
//   in_inst      raw instruction
//   out_valid    out_* hold a decoded entry
//   out_ready    EX consumes the entry this cycle
//   out_imm      extended immediate
//   out_fmt      0 NONE/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
//   out_illegal  opcode/shamt not legal for this XLEN
//   out_inst     instruction passed through with the entry
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid may not change its payload until the
// transfer. The stage never withdraws out_valid or changes out_* while
// out_valid && !out_ready. The only exceptions are flush and reset.
// -----------------------------------------------------------------------------
module imm_gen_stage #(
    parameter int XLEN = 64,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_inst
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ZIMM  = 3'd7
    } fmt_e;

    // Entry layout: {inst, illegal, fmt, imm}
    localparam int EW = 32 + 1 + 3 + XLEN;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        sign;
    logic        is_shift;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign sign     = in_inst[31];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // ------------------------------------------------------------------
    // Decode. The immediate is always built 64 bits wide and truncated to
    // XLEN. For XLEN=32 the sign extension then lands at bit 31 naturally.
    // ------------------------------------------------------------------
    logic [63:0] imm64;
    fmt_e        fmt;
    logic        illegal;

    always_comb begin
        imm64   = 64'd0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            7'b0010011: begin // OP-IMM
                if (is_shift) begin
                    fmt = FMT_SHAMT;
                    if (XLEN == 64) begin
                        imm64 = {58'd0, in_inst[25:20]};
                    end else begin
                        // RV32 shamt is 5 bits; bit 25 set is reserved
                        imm64   = {59'd0, in_inst[24:20]};
                        illegal = in_inst[25];
                    end
                end else begin
                    fmt   = FMT_I;
                    imm64 = {{52{sign}}, in_inst[31:20]};
                end
            end
            7'b0011011: begin // OP-IMM-32, RV64 only
                if (XLEN == 64) begin
                    if (is_shift) begin
                        fmt   = FMT_SHAMT;
                        imm64 = {59'd0, in_inst[24:20]};
                    end else if (funct3 == 3'b000) begin
                        fmt   = FMT_I;
                        imm64 = {{52{sign}}, in_inst[31:20]};
                    end else begin
                        // no other OP-IMM-32 encodings exist
                        illegal = 1'b1;
                    end
                end else begin
                    illegal = 1'b1;
                end
            end
            7'b0000011, 7'b1100111: begin // LOAD, JALR
                fmt   = FMT_I;
                imm64 = {{52{sign}}, in_inst[31:20]};
            end
            7'b0100011: begin // STORE
                fmt   = FMT_S;
                imm64 = {{52{sign}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin // BRANCH
                fmt   = FMT_B;
                imm64 = {{51{sign}}, in_inst[31], in_inst[7], in_inst[30:25],
                         in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin // LUI, AUIPC
                fmt   = FMT_U;
                imm64 = {{32{sign}}, in_inst[31:12], 12'd0};
            end
            7'b1101111: begin // JAL
                fmt   = FMT_J;
                imm64 = {{43{sign}}, in_inst[31], in_inst[19:12], in_inst[20],
                         in_inst[30:21], 1'b0};
            end
            7'b1110011: begin // SYSTEM; funct3[2] selects the CSR *I forms
                if (funct3[2]) begin
                    fmt   = FMT_ZIMM;
                    imm64 = {59'd0, in_inst[19:15]};
                end
            end
            7'b0110011, 7'b0001111: begin // OP, FENCE: no immediate
            end
            7'b0111011: begin // OP-32
                illegal = (XLEN == 32);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    logic [EW-1:0] entry_d;
    assign entry_d = {in_inst, illegal, fmt, imm64[XLEN-1:0]};

    // ------------------------------------------------------------------
    // Output register plus optional skid entry
    // ------------------------------------------------------------------
    logic [EW-1:0] out_q, out_d;
    logic [EW-1:0] skid_q, skid_d;
    logic          out_valid_q, out_valid_d;
    logic          skid_full_q, skid_full_d;
    logic          accept, consume;

    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = !skid_full_q;
        end else begin : g_plain_ready
            assign in_ready = out_ready || !out_valid_q;
        end
    endgenerate

    assign accept  = in_valid && in_ready;
    assign consume = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        skid_full_d = skid_full_q;
        skid_d      = skid_q;
        if (flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (skid_full_q) begin
            // in_ready is low here, so only the skid drains; it is older than
            // anything still upstream.
            if (consume) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || consume) begin
                out_d       = entry_d;
                out_valid_d = 1'b1;
            end else begin
                // Output stalled; only reachable with SKID=1.
                skid_d      = entry_d;
                skid_full_d = 1'b1;
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_full_q <= 1'b0;
            skid_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            skid_full_q <= skid_full_d;
            skid_q      <= skid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign {out_inst, out_illegal, out_fmt, out_imm} = out_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_stage
//   Two instances: dut (XLEN=64, SKID=1) and dut32 (XLEN=32, SKID=0).
//   Drivers push hand-computed expected entries {inst, illegal, fmt, imm64}
//   when an input is accepted. Monitors pop and compare on each consumed output.
//   Inputs change on the falling edge. Checks run 1-2 time units after it.
// -----------------------------------------------------------------------------
module tb_imm_gen_stage;

    localparam int W = 100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        out_ready;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [31:0] out_inst;

    logic        in_valid32;
    logic [31:0] in_inst32;
    logic        out_ready32;
    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic        out_illegal32;
    logic [31:0] out_inst32;

    imm_gen_stage #(.XLEN(64), .SKID(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_inst(out_inst)
    );

    imm_gen_stage #(.XLEN(32), .SKID(0)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_inst(in_inst32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_inst(out_inst32)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    int last_wait;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp32_q[$];

    // Directed vectors for XLEN=64: inst, imm, fmt, illegal
    logic [31:0] v_inst [14] = '{
        32'hFFF00093, 32'h03F09093, 32'h800000B7, 32'hFE000EE3, 32'h0020A423,
        32'h0080006F, 32'h3002D073, 32'h00000073, 32'h002081B3, 32'hFF812083,
        32'h0010809B, 32'h01F0909B, 32'h12345097, 32'h0000007F};
    logic [63:0] v_imm [14] = '{
        64'hFFFFFFFFFFFFFFFF, 64'd63, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC,
        64'd8, 64'd8, 64'd5, 64'd0, 64'd0, 64'hFFFFFFFFFFFFFFF8,
        64'd1, 64'd31, 64'h0000000012345000, 64'd0};
    logic [2:0] v_fmt [14] = '{3'd1, 3'd6, 3'd4, 3'd3, 3'd2, 3'd5, 3'd7,
                               3'd0, 3'd0, 3'd1, 3'd1, 3'd6, 3'd4, 3'd0};
    logic       v_ill [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Directed vectors for XLEN=32
    logic [31:0] w_inst [6] = '{32'h03F09093, 32'h00509093, 32'h800000B7,
                                32'h0010809B, 32'h002080BB, 32'hFFF00093};
    logic [63:0] w_imm [6]  = '{64'd31, 64'd5, 64'h80000000, 64'd0, 64'd0, 64'hFFFFFFFF};
    logic [2:0]  w_fmt [6]  = '{3'd6, 3'd6, 3'd4, 3'd0, 3'd0, 3'd1};
    logic        w_ill [6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic send(input int idx);
        int n = 0;
        in_valid = 1'b1;
        in_inst  = v_inst[idx];
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        last_wait = n;
        if (in_ready) begin
            exp_q.push_back({v_inst[idx], v_ill[idx], v_fmt[idx], v_imm[idx]});
        end else begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stuck at 0 for inst %h", v_inst[idx]);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send32(input int idx);
        int n = 0;
        in_valid32 = 1'b1;
        in_inst32  = w_inst[idx];
        #1;
        while (!in_ready32 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready32) begin
            exp32_q.push_back({w_inst[idx], w_ill[idx], w_fmt[idx], w_imm[idx]});
        end else begin
            total++;
            bad++;
            $display("FAIL send32_timeout: in_ready stuck at 0 for inst %h", w_inst[idx]);
        end
        @(negedge clk);
        in_valid32 = 1'b0;
    endtask

    // ---------------- monitors ----------------
    initial begin : mon64
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && !flush && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got inst %h, queue empty", out_inst);
                end else begin
                    e = exp_q.pop_front();
                    check("out_imm", out_imm, e[63:0]);
                    check("out_fmt", 64'(out_fmt), 64'(e[66:64]));
                    check("out_illegal", 64'(out_illegal), 64'(e[67]));
                    check("out_inst", 64'(out_inst), 64'(e[99:68]));
                end
            end
        end
    end

    initial begin : mon32
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && !flush && out_valid32 && out_ready32) begin
                if (exp32_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out32: got inst %h, queue empty", out_inst32);
                end else begin
                    e = exp32_q.pop_front();
                    check("out32_imm", 64'(out_imm32), e[63:0]);
                    check("out32_fmt", 64'(out_fmt32), 64'(e[66:64]));
                    check("out32_illegal", 64'(out_illegal32), 64'(e[67]));
                    check("out32_inst", 64'(out_inst32), 64'(e[99:68]));
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_inst     = 32'd0;
        out_ready   = 1'b1;
        in_valid32  = 1'b0;
        in_inst32   = 32'd0;
        out_ready32 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_imm", out_imm, 64'd0);
        check("rst_out_fmt", 64'(out_fmt), 64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_in_ready32", 64'(in_ready32), 64'd1);

        // addi, then latency 1
        @(negedge clk);
        send(0);
        #1;
        check("lat1_out_valid", 64'(out_valid), 64'd1);

        // Remaining vectors back-to-back with out_ready high
        @(negedge clk);
        for (int i = 1; i < 14; i++) begin
            send(i);
            check("thru_no_wait", 64'(last_wait), 64'd0);
        end
        repeat (3) @(negedge clk);
        #1;
        check("thru_drained", 64'(out_valid), 64'd0);

        // XLEN=32 instance
        @(negedge clk);
        for (int i = 0; i < 6; i++) send32(i);
        repeat (3) @(negedge clk);

        // Skid stall: 3 entries, out_ready low
        out_ready = 1'b0;
        send(2);
        #1;
        check("skid_ready_after_1", 64'(in_ready), 64'd1);
        @(negedge clk);
        send(3);
        fork
            send(4);
            begin
                for (int k = 0; k < 3; k++) begin
                    #1;
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_out_valid", 64'(out_valid), 64'd1);
                    check("stall_out_inst", 64'(out_inst), 64'(v_inst[2]));
                    check("stall_out_imm", out_imm, v_imm[2]);
                    @(negedge clk);
                end
                out_ready = 1'b1;
                @(negedge clk);
                #1;
                check("release_out_inst_b", 64'(out_inst), 64'(v_inst[3]));
            end
        join
        #1;
        check("release_out_inst_c", 64'(out_inst), 64'(v_inst[4]));
        check("release_out_valid_c", 64'(out_valid), 64'd1);
        @(negedge clk);
        #1;
        check("release_drained", 64'(out_valid), 64'd0);

        // Flush with out and skid full, in_valid high
        @(negedge clk);
        out_ready = 1'b0;
        send(5);
        send(6);
        in_valid = 1'b1;
        in_inst  = v_inst[7];
        flush    = 1'b1;
        exp_q.delete();
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("flush_dropped", 64'(out_valid), 64'd0);

        // Flush while in_ready=1: input still dropped
        @(negedge clk);
        in_valid = 1'b1;
        in_inst  = v_inst[8];
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_ready_drop", 64'(out_valid), 64'd0);

        // Reset mid-stream with out_valid high
        @(negedge clk);
        out_ready = 1'b0;
        send(12);
        #1;
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_inst  = v_inst[0];
        exp_q.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_imm", out_imm, 64'd0);
        check("mid_rst_out_fmt", 64'(out_fmt), 64'd0);
        check("mid_rst_out_illegal", 64'(out_illegal), 64'd0);
        check("mid_rst_out_inst", 64'(out_inst), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);

        // Illegal opcode flows through after reset
        @(negedge clk);
        out_ready = 1'b1;
        send(13);
        #1;
        check("illegal_out_valid", 64'(out_valid), 64'd1);
        check("illegal_flag", 64'(out_illegal), 64'd1);

        repeat (4) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("exp32_q_empty", 64'(exp32_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
